// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: register map, bit positions, FSM states.
package spi_target_pkg;

  // Word addresses within the register window (wb_adr_i[3:2])
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_UNDERRUN = 3;
  localparam int ST_SELECTED = 4;

  // CTRL bit positions
  localparam int CT_ENABLE = 0;
  localparam int CT_IE_RX  = 1;
  localparam int CT_IE_TX  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchroniser for an asynchronous pad, followed by a registered
// edge detector. The level output is the delayed copy the edge detector
// compares against, so level and the pulses refer to the same sample.
module spi_target_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  // Synchronise the pad and produce one-cycle rise/fall pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= RST_VAL;
      sync  <= RST_VAL;
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= din;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/spi_target_wb.sv
// SPI target (mode 0, MSB first) with a Wishbone classic register interface.
// Pads are oversampled in the Wishbone clock domain; one word is received
// into RXDATA and one CPU-loaded word is shifted out per CHAR_LEN clocks.
module spi_target_wb
  import spi_target_pkg::*;
#(
  parameter int CHAR_LEN = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [4:2]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_err_o,
  output logic        int_o,
  input  logic        cs_n_i,
  input  logic        sck_i,
  input  logic        sdi_i,
  output logic        sdo_o,
  output logic        sdo_oe_o
);

  localparam int CNT_W = $clog2(CHAR_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAR_LEN - 1);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic sdi_level, sdi_rise, sdi_fall;

  spi_target_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(cs_n_i),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall));
  spi_target_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(sck_i),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall));
  spi_target_sync #(.RST_VAL(1'b0)) u_sync_sdi (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(sdi_i),
    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall));

  state_t state, state_next;
  logic enter, leave, rx_sample, tx_fall;

  logic [CNT_W-1:0]    bit_cnt;
  logic [CHAR_LEN-1:0] rx_shift, tx_shift, rx_data, tx_hold;
  logic                reload_pending;
  logic                rx_valid, tx_empty, overrun, underrun;
  logic [2:0]          ctrl;

  logic enable;
  assign enable = ctrl[CT_ENABLE];

  // Bus decode: a new access is one not already being answered
  logic       access, bad_adr;
  logic [1:0] reg_sel;
  logic       rx_read, tx_write, status_write, ctrl_write;
  assign access       = wb_stb_i & wb_cyc_i & ~wb_ack_o & ~wb_err_o;
  assign bad_adr      = wb_adr_i[4];
  assign reg_sel      = wb_adr_i[3:2];
  assign rx_read      = access & ~bad_adr & ~wb_we_i & (reg_sel == REG_RXDATA);
  assign tx_write     = access & ~bad_adr &  wb_we_i & (reg_sel == REG_TXDATA);
  assign status_write = access & ~bad_adr &  wb_we_i & (reg_sel == REG_STATUS);
  assign ctrl_write   = access & ~bad_adr &  wb_we_i & (reg_sel == REG_CTRL);

  logic [CHAR_LEN-1:0] rx_word, tx_next;
  logic                word_done, tx_load;
  assign rx_word   = {rx_shift[CHAR_LEN-2:0], sdi_level};
  assign tx_next   = tx_empty ? '0 : tx_hold;
  assign word_done = rx_sample & (bit_cnt == LAST_BIT);
  assign tx_load   = enter | (tx_fall & reload_pending);
  assign sdo_oe_o  = (state == SHIFT) & enable;

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and the per-cycle shift strobes; leaving SHIFT wins over sck edges
  always_comb begin
    state_next = state;
    enter      = 1'b0;
    leave      = 1'b0;
    rx_sample  = 1'b0;
    tx_fall    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && enable) begin
          state_next = SHIFT;
          enter      = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise || !enable) begin
          state_next = IDLE;
          leave      = 1'b1;
        end else begin
          rx_sample = sck_rise;
          tx_fall   = sck_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter and MISO driver
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      reload_pending <= 1'b0;
      sdo_o          <= 1'b0;
    end else if (enter) begin
      bit_cnt        <= '0;
      reload_pending <= 1'b0;
      tx_shift       <= tx_next;
      sdo_o          <= tx_next[CHAR_LEN-1];
    end else if (leave) begin
      bit_cnt        <= '0;
      reload_pending <= 1'b0;
      sdo_o          <= 1'b0;
    end else if (rx_sample) begin
      rx_shift <= rx_word;
      if (bit_cnt == LAST_BIT) begin
        bit_cnt        <= '0;
        reload_pending <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else if (tx_fall) begin
      if (reload_pending) begin
        tx_shift       <= tx_next;
        sdo_o          <= tx_next[CHAR_LEN-1];
        reload_pending <= 1'b0;
      end else begin
        tx_shift <= {tx_shift[CHAR_LEN-2:0], 1'b0};
        sdo_o    <= tx_shift[CHAR_LEN-2];
      end
    end
  end

  // Holding registers and status flags; later statements take priority,
  // so a TX write lands after a same-cycle reload consumed the old word
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_hold  <= '0;
      tx_empty <= 1'b1;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      ctrl     <= '0;
    end else begin
      if (word_done) begin
        if (!rx_valid || rx_read) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end
      end else if (rx_read) begin
        rx_valid <= 1'b0;
      end
      if (status_write && wb_dat_i[ST_OVERRUN]) overrun <= 1'b0;
      if (word_done && rx_valid && !rx_read)    overrun <= 1'b1;
      if (status_write && wb_dat_i[ST_UNDERRUN]) underrun <= 1'b0;
      if (tx_load) begin
        if (tx_empty) underrun <= 1'b1;
        else          tx_empty <= 1'b1;
      end
      if (tx_write) begin
        tx_hold  <= wb_dat_i[CHAR_LEN-1:0];
        tx_empty <= 1'b0;
      end
      if (ctrl_write) ctrl <= wb_dat_i[2:0];
    end
  end

  // Read data multiplexer
  logic [31:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_RXDATA: rd_data = 32'(rx_data);
      REG_STATUS: begin
        rd_data[ST_RX_VALID] = rx_valid;
        rd_data[ST_TX_EMPTY] = tx_empty;
        rd_data[ST_OVERRUN]  = overrun;
        rd_data[ST_UNDERRUN] = underrun;
        rd_data[ST_SELECTED] = (state == SHIFT);
      end
      REG_CTRL:   rd_data[2:0] = ctrl;
      default:    rd_data = '0;
    endcase
  end

  // Single-cycle ack/err pulse; read data is captured and held until the next read
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access & ~bad_adr;
      wb_err_o <= access & bad_adr;
      if (access && !bad_adr && !wb_we_i) wb_dat_o <= rd_data;
    end
  end

  // Registered interrupt combining the enabled sources
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) int_o <= 1'b0;
    else int_o <= ((rx_valid & ctrl[CT_IE_RX]) | (tx_empty & ctrl[CT_IE_TX]) |
                   overrun | underrun) & enable;
  end

  logic unused;
  assign unused = ^{wb_sel_i, wb_dat_i, cs_level, sck_level, sdi_rise, sdi_fall};

endmodule

// File: tb/tb_spi_target_wb.sv
// Self-checking bench for spi_target_wb: drives an SPI master and Wishbone
// host, and compares against a transaction-level model of the registers.
module tb_spi_target_wb;

  localparam int CL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:2]  wb_adr;
  logic [31:0] wb_wdat, wb_rdat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err, int_o;
  logic        cs_n, sck, sdi, sdo, sdo_oe;

  always #5 clk = ~clk;

  spi_target_wb #(.CHAR_LEN(CL)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_wdat),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
    .wb_ack_o(wb_ack), .wb_dat_o(wb_rdat), .wb_err_o(wb_err), .int_o(int_o),
    .cs_n_i(cs_n), .sck_i(sck), .sdi_i(sdi), .sdo_o(sdo), .sdo_oe_o(sdo_oe));

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic mon_en = 1'b0;

  // Behavioural model of the programmer-visible state
  logic [7:0] m_rx_data, m_tx_hold;
  logic       m_rx_valid, m_tx_empty, m_ovr, m_und, m_sel;
  logic [2:0] m_ctrl;
  logic [7:0] last_miso;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] modelStatus();
    return {27'b0, m_sel, m_und, m_ovr, m_tx_empty, m_rx_valid};
  endfunction

  function automatic logic modelInt();
    return ((m_rx_valid & m_ctrl[1]) | (m_tx_empty & m_ctrl[2]) | m_ovr | m_und) & m_ctrl[0];
  endfunction

  task automatic modelReset();
    m_rx_data = 0; m_tx_hold = 0; m_rx_valid = 0; m_tx_empty = 1;
    m_ovr = 0; m_und = 0; m_sel = 0; m_ctrl = 0;
  endtask

  // A word is taken for transmission: the pending TX word, or zeros on underrun
  task automatic modelLoad(output logic [7:0] cur);
    if (!m_tx_empty) begin
      cur = m_tx_hold;
      m_tx_empty = 1;
    end else begin
      cur = 8'h00;
      m_und = 1;
    end
  endtask

  task automatic modelWord(input logic [7:0] w);
    if (!m_rx_valid) begin
      m_rx_data = w;
      m_rx_valid = 1;
    end else begin
      m_ovr = 1;
    end
  endtask

  // Continuous compare of the level outputs whenever the bench is quiescent
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checkOutput("int_o", {31'b0, int_o}, {31'b0, modelInt()});
      checkOutput("sdo_oe", {31'b0, sdo_oe}, {31'b0, m_sel & m_ctrl[0]});
    end
  end

  task automatic settle();
    repeat (6) @(negedge clk);
    mon_en = 1;
  endtask

  task automatic wbAccess(input logic we, input logic [2:0] adr, input logic [31:0] wd,
                          output logic [31:0] rd);
    int n;
    mon_en = 0;
    @(negedge clk);
    wb_we = we; wb_adr = adr; wb_wdat = wd; wb_stb = 1; wb_cyc = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wb_ack || wb_err) && n < 8);
    checkOutput("wb_latency", n, 1);
    checkOutput("wb_ack_err", {30'b0, wb_ack, wb_err}, adr[2] ? 32'h1 : 32'h2);
    rd = wb_rdat;
    wb_stb = 0; wb_cyc = 0; wb_we = 0;
    @(negedge clk);
    checkOutput("wb_pulse", {30'b0, wb_ack, wb_err}, 0);
  endtask

  task automatic wbWrite(input logic [2:0] adr, input logic [31:0] wd);
    logic [31:0] rd;
    wbAccess(1'b1, adr, wd, rd);
    if (!adr[2]) begin
      case (adr[1:0])
        2'd1: begin m_tx_hold = wd[7:0]; m_tx_empty = 0; end
        2'd2: begin if (wd[2]) m_ovr = 0; if (wd[3]) m_und = 0; end
        2'd3: m_ctrl = wd[2:0];
        default: ;
      endcase
    end
    settle();
  endtask

  task automatic wbRead(input logic [2:0] adr, output logic [31:0] rd);
    logic [31:0] exp;
    case (adr[1:0])
      2'd0: exp = {24'b0, m_rx_data};
      2'd2: exp = modelStatus();
      2'd3: exp = {29'b0, m_ctrl};
      default: exp = 0;
    endcase
    wbAccess(1'b0, adr, 32'h0, rd);
    if (!adr[2]) begin
      checkOutput("wb_read", rd, exp);
      if (adr[1:0] == 2'd0) m_rx_valid = 0;
    end
    settle();
  endtask

  // SPI master frame: mode 0, half period 6 system clocks; MISO checked before each rise
  task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                               input int nwords, input int abort_bits);
    logic [7:0] cur, word;
    int sent;
    mon_en = 0;
    @(negedge clk);
    cs_n = 0; m_sel = 1;
    modelLoad(cur);
    last_miso = 0; sent = 0;
    for (int w = 0; w < nwords; w++) begin
      word = (w == 0) ? w0 : w1;
      for (int b = CL - 1; b >= 0; b--) begin
        if (abort_bits > 0 && sent == abort_bits) break;
        sdi = word[b];
        #60;
        checkOutput("miso", {31'b0, sdo}, {31'b0, cur[b]});
        checkOutput("miso_oe", {31'b0, sdo_oe}, 1);
        last_miso = {last_miso[6:0], sdo};
        sck = 1; #60; sck = 0;
        sent++;
      end
      // The trailing SCK fall of a complete word reloads the transmitter
      if (abort_bits == 0) begin
        modelWord(word);
        modelLoad(cur);
      end
    end
    #60;
    cs_n = 1; m_sel = 0; sdi = 0;
    repeat (8) @(negedge clk);
    mon_en = 1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  r0, r1;
    int          op;

    rst = 1; cs_n = 1; sck = 0; sdi = 0;
    wb_adr = 0; wb_wdat = 0; wb_sel = 4'hF; wb_we = 0; wb_stb = 0; wb_cyc = 0;
    modelReset();
    #2;
    checkOutput("rst_ack", {31'b0, wb_ack}, 0);
    checkOutput("rst_err", {31'b0, wb_err}, 0);
    checkOutput("rst_dat", wb_rdat, 0);
    checkOutput("rst_int", {31'b0, int_o}, 0);
    checkOutput("rst_sdo", {31'b0, sdo}, 0);
    checkOutput("rst_sdo_oe", {31'b0, sdo_oe}, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    mon_en = 1;

    wbRead(3'd2, rd);
    checkOutput("status_reset_lit", rd, 32'h2);
    wbRead(3'd3, rd);

    // Single word both ways
    wbWrite(3'd3, 32'h1);
    wbWrite(3'd1, 32'hA5);
    applyStimulus(8'h3C, 8'h00, 1, 0);
    checkOutput("miso_a5_lit", {24'b0, last_miso}, 32'hA5);
    wbRead(3'd2, rd);
    checkOutput("status_rx_tx_lit", rd & 32'h3, 32'h3);
    wbRead(3'd0, rd);
    checkOutput("rx_3c_lit", rd, 32'h3C);

    // Overrun: second word dropped
    applyStimulus(8'h11, 8'h00, 1, 0);
    applyStimulus(8'h22, 8'h00, 1, 0);
    wbRead(3'd0, rd);
    checkOutput("rx_11_lit", rd, 32'h11);
    wbRead(3'd2, rd);
    checkOutput("overrun_set_lit", {31'b0, rd[2]}, 1);
    wbWrite(3'd2, 32'h4);
    wbRead(3'd2, rd);
    checkOutput("overrun_clr_lit", {31'b0, rd[2]}, 0);

    // Underrun with empty TX and ie_tx
    wbWrite(3'd2, 32'hC);
    wbWrite(3'd3, 32'h5);
    mon_en = 0;
    @(negedge clk);
    cs_n = 0; m_sel = 1;
    modelLoad(r0);
    settle();
    checkOutput("int_underrun_lit", {31'b0, int_o}, 1);
    wbRead(3'd2, rd);
    checkOutput("underrun_lit", {31'b0, rd[3]}, 1);
    checkOutput("selected_lit", {31'b0, rd[4]}, 1);
    mon_en = 0;
    @(negedge clk);
    cs_n = 1; m_sel = 0;
    settle();
    applyStimulus(8'h55, 8'h00, 1, 0);
    checkOutput("miso_zero_lit", {24'b0, last_miso}, 0);

    // Aborted frame followed by a full one
    wbRead(3'd0, rd);
    applyStimulus(8'h7E, 8'h00, 1, 5);
    wbRead(3'd2, rd);
    checkOutput("abort_no_rx_lit", {31'b0, rd[0]}, 0);
    applyStimulus(8'h7E, 8'h00, 1, 0);
    wbRead(3'd0, rd);
    checkOutput("rx_7e_lit", rd, 32'h7E);

    // Out-of-range addresses
    wbRead(3'd5, rd);
    wbWrite(3'd6, 32'hFFFF_FFFF);

    // Randomised mix of CPU and SPI traffic
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 6);
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      case (op)
        0: wbWrite(3'd1, {24'($urandom), r0});
        1: applyStimulus(r0, r1, $urandom_range(1, 2), 0);
        2: wbRead(3'd0, rd);
        3: wbRead(3'($urandom_range(2, 7)), rd);
        4: wbWrite(3'd2, 32'($urandom_range(0, 31)));
        5: applyStimulus(r0, r1, 1, $urandom_range(1, 7));
        default: wbWrite(3'd3, {29'b0, r0[1:0], 1'b1});
      endcase
    end

    // Reset in the middle of a word
    wbWrite(3'd1, 32'h5A);
    wbRead(3'd3, rd);
    mon_en = 0;
    @(negedge clk);
    cs_n = 0; sdi = 1;
    #60; sck = 1; #60; sck = 0; #60; sck = 1; #20;
    rst = 1;
    #1;
    checkOutput("mid_rst_ack", {31'b0, wb_ack}, 0);
    checkOutput("mid_rst_err", {31'b0, wb_err}, 0);
    checkOutput("mid_rst_dat", wb_rdat, 0);
    checkOutput("mid_rst_int", {31'b0, int_o}, 0);
    checkOutput("mid_rst_sdo", {31'b0, sdo}, 0);
    checkOutput("mid_rst_sdo_oe", {31'b0, sdo_oe}, 0);
    #9;
    cs_n = 1; sck = 0; sdi = 0;
    @(negedge clk);
    rst = 0;
    modelReset();
    wbRead(3'd2, rd);
    checkOutput("mid_rst_status_lit", rd, 32'h2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_target_wb.md
# spi_target_wb

SPI target (peripheral-side) controller with a Wishbone classic slave register interface; the counterpart of the team's Wishbone SPI master core. An external SPI master drives chip select, clock and MOSI. The block deserialises received words into an RX holding register and serialises a CPU-loaded TX word onto MISO. All pad inputs are oversampled in the single Wishbone clock domain. Supports SPI mode 0 only, MSB first.

## Interface
Parameters:
- CHAR_LEN, 8: bits per SPI word, 4..32.

Ports:
- wb_clk_i  in  1  system clock; also the oversampling clock.
- wb_rst_i  in  1  reset; asynchronous and active-high.
- wb_adr_i  in  [4:2]  word address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects. Ignored; writes are always full-word.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  32  read data.
- wb_err_o  out  1  error; asserted instead of ack for addresses 4..7.
- int_o  out  1  interrupt: (rx_valid & ie_rx) | (tx_empty & ie_tx) | overrun | underrun, ANDed with enable.
- cs_n_i  in  1  chip select from master, active-low, asynchronous.
- sck_i  in  1  SPI clock from master, asynchronous.
- sdi_i  in  1  MOSI, asynchronous.
- sdo_o  out  1  MISO data.
- sdo_oe_o  out  1  MISO output enable. High only while selected, shifting, and CTRL.enable=1.

## Operation
- Register map (wb_adr_i):
  - 0 RXDATA, read-only. Reading returns the data and clears rx_valid.
  - 1 TXDATA, write-only. Writing loads tx_hold and clears tx_empty.
  - 2 STATUS. Bits: 0 rx_valid, 1 tx_empty, 2 overrun, 3 underrun, 4 selected. Bits 2/3 are write-1-to-clear.
  - 3 CTRL, read/write. Bits: 0 enable, 1 ie_rx, 2 ie_tx.
  - Unused bits read 0.
- Input conditioning: cs_n_i, sck_i and sdi_i each pass a 2-FF synchroniser, then a registered edge detector.
- FSM states: IDLE, SHIFT.
- IDLE -> SHIFT on a synchronised cs_n falling edge while enable=1:
  - bit_cnt := 0.
  - tx_shift := tx_hold if tx_empty=0, and tx_empty is set. Otherwise tx_shift := 0 and underrun is set.
  - sdo_o := tx_shift MSB.
- In SHIFT:
  - sck rising edge: rx_shift := {rx_shift, sdi}; bit_cnt++.
  - On the rising edge where bit_cnt = CHAR_LEN-1, the word is complete:
    - If rx_valid=0: rx_data := word, rx_valid := 1.
    - If rx_valid=1: the word is dropped, rx_data is unchanged, overrun := 1.
    - bit_cnt := 0 and a reload is flagged.
  - sck falling edge: if a reload is flagged, reload tx_shift exactly as on CS fall. Otherwise shift left. In both cases drive the MSB.
- SHIFT -> IDLE on a cs_n rising edge, or when enable clears. Partial RX bits are discarded, bit_cnt is reset, sdo_oe_o goes low, and tx_hold is untouched.
- Simultaneous events in the same cycle:
  - CPU read of RXDATA and word completion: the read returns the old data, and the new word is stored with rx_valid=1 and no overrun.
  - CPU write of TXDATA and reload: the reload takes the old tx_hold state; the write then sets tx_hold and clears tx_empty.
- Wishbone: ack (or err) is a one-cycle pulse in the cycle after stb&cyc when ack is low. Back-to-back accesses therefore complete every second cycle.

## Timing
- Reset values:
  - All outputs 0: wb_ack_o, wb_err_o, wb_dat_o, int_o, sdo_o, sdo_oe_o.
  - STATUS = tx_empty=1, all other bits 0. CTRL = 0. FSM = IDLE.
- Pad-to-action latency: 3 wb_clk_i cycles (2 sync, 1 edge register). sdo_o updates on the following clock, 4 cycles after a pad sck fall.
- Requirement: f(wb_clk_i) >= 10 x f(sck_i), so that MISO is valid before the master samples on the rising edge.
- rx_valid rises 1 cycle after the detected final rising edge, 4 cycles after the pad edge.
- int_o is registered: 1 cycle after its source flag changes.
- wb_dat_o is valid in the ack cycle and holds its value until the next access.

## Structure
- Package spi_target_pkg holds:
  - register address localparams (RXDATA, TXDATA, STATUS, CTRL);
  - STATUS and CTRL bit-index localparams;
  - the FSM enum typedef {IDLE, SHIFT}.
- Sub-module spi_target_sync: 2-FF synchroniser plus rise/fall pulse outputs, reset value parameterised (1 for cs_n, 0 for sck and sdi). Instantiated three times.

## Test plan
- CHAR_LEN=8. CPU writes TXDATA=0xA5. Master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RXDATA reads 0x3C; STATUS = rx_valid=1, tx_empty=1 before the read.
- Two words sent without an RXDATA read (0x11, then 0x22) -> RXDATA=0x11, overrun=1. Writing STATUS=0x4 clears overrun.
- CS asserted with tx_empty=1 -> MISO 0x00, underrun=1; with ie_tx=1, int_o=1.
- CS deasserted after 5 of 8 clocks, then a full 0x7E word -> rx_valid stays 0 after the abort; RXDATA=0x7E after the full word.
- Read of address 5 -> wb_err_o pulses for 1 cycle, wb_ack_o stays 0. Assert wb_rst_i mid-word -> all outputs 0 immediately and STATUS=0x2.
